// File: rtl/mdu_issue_pkg.sv
// Shared MDU issue constants: MDUOp encodings, busy-window defaults and
// tracker state codes, plus small op-classification helpers.
package mdu_issue_pkg;

    localparam logic [3:0] MDUOP_NONE  = 4'd0;
    localparam logic [3:0] MDUOP_MULT  = 4'd1;
    localparam logic [3:0] MDUOP_MULTU = 4'd2;
    localparam logic [3:0] MDUOP_DIV   = 4'd3;
    localparam logic [3:0] MDUOP_DIVU  = 4'd4;
    localparam logic [3:0] MDUOP_MFHI  = 4'd5;
    localparam logic [3:0] MDUOP_MFLO  = 4'd6;
    localparam logic [3:0] MDUOP_MTHI  = 4'd7;
    localparam logic [3:0] MDUOP_MTLO  = 4'd8;

    localparam int MUL_BUSY_DEFAULT = 6;
    localparam int DIV_BUSY_DEFAULT = 11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == MDUOP_MULT) || (op == MDUOP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDUOP_DIV) || (op == MDUOP_DIVU);
    endfunction

    // HI/LO moves must not be issued while a mult/div is still in flight.
    function automatic logic is_hilo_move(input logic [3:0] op);
        return (op == MDUOP_MFHI) || (op == MDUOP_MFLO) ||
               (op == MDUOP_MTHI) || (op == MDUOP_MTLO);
    endfunction

endpackage

// File: rtl/mdu_issue_sat_counter.sv
// Saturating up-counter with synchronous clear and load; holds at all-ones.
module mdu_issue_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mdu_issue.sv
// E-stage issue/interlock for the multiply-divide unit: drives the MDU, shadows
// its busy window with a down-counter, stalls D and flags protocol violations.
//
// state   | meaning
// IDLE    | no tracked mult/div in flight
// MUL     | mult/multu issued, cnt counting down MUL_BUSY
// DIV     | div/divu issued, cnt counting down DIV_BUSY
module mdu_issue
    import mdu_issue_pkg::*;
#(
    parameter int MUL_BUSY = MUL_BUSY_DEFAULT,
    parameter int DIV_BUSY = DIV_BUSY_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_valid,
    input  logic [3:0]  d_op,
    input  logic        e_valid,
    input  logic [3:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    output logic [31:0] mdu_a,
    output logic [31:0] mdu_b,
    output logic [3:0]  mdu_op,
    output logic        mdu_start,
    input  logic        mdu_busy,
    output logic        stall_md,
    output logic        proto_err,
    output logic [31:0] stall_cycles
);

    localparam int BUSY_MAX = (MUL_BUSY > DIV_BUSY) ? MUL_BUSY : DIV_BUSY;
    localparam int CNT_W    = $clog2(BUSY_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic             proto_err_q, proto_err_d;
    logic             start_mul, start_div, own_busy, move_conflict, busy_mismatch;

    assign mdu_a  = e_rs;
    assign mdu_b  = e_rt;
    assign mdu_op = e_valid ? e_op : MDUOP_NONE;

    assign start_mul = e_valid && is_mul_op(e_op);
    assign start_div = e_valid && is_div_op(e_op);
    assign mdu_start = start_mul || start_div;
    assign own_busy  = (cnt_q != '0);

    assign stall_md = d_valid && (d_op != MDUOP_NONE) && (mdu_start || own_busy || mdu_busy);

    // The MDU drops busy in its Start cycle, so the busy cross-check skips it.
    assign move_conflict = e_valid && is_hilo_move(e_op) && own_busy;
    assign busy_mismatch = !mdu_start && (mdu_busy != own_busy);

    always_comb begin
        cnt_d       = cnt_q;
        state_d     = state_q;
        proto_err_d = proto_err_q | (mdu_start && own_busy) | move_conflict | busy_mismatch;
        if (start_mul) begin
            cnt_d   = CNT_W'(MUL_BUSY);
            state_d = ST_MUL;
        end else if (start_div) begin
            cnt_d   = CNT_W'(DIV_BUSY);
            state_d = ST_DIV;
        end else if (own_busy) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            proto_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;

    mdu_issue_sat_counter #(
        .WIDTH(32)
    ) u_stall_cnt (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (stall_md),
        .load_i     (1'b0),
        .load_val_i (32'h0),
        .count_o    (stall_cycles)
    );

endmodule

// File: tb/tb_mdu_issue.sv
// Directed bench for mdu_issue: expectations are queued as each cycle's
// stimulus is driven and popped/checked on the following falling edge.
module tb_mdu_issue;
    import mdu_issue_pkg::*;

    localparam int S_START = 0;
    localparam int S_STALL = 1;
    localparam int S_ERR   = 2;
    localparam int S_SCNT  = 3;
    localparam int S_STATE = 4;
    localparam int S_CNT   = 5;
    localparam int S_OP    = 6;
    localparam int S_A     = 7;
    localparam int S_B     = 8;
    localparam int S_SAT   = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid;
    logic [3:0]  d_op;
    logic        e_valid;
    logic [3:0]  e_op;
    logic [31:0] e_rs, e_rt;
    logic [31:0] mdu_a, mdu_b;
    logic [3:0]  mdu_op;
    logic        mdu_start;
    logic        mdu_busy;
    logic        stall_md;
    logic        proto_err;
    logic [31:0] stall_cycles;

    logic        sat_reset, sat_inc, sat_load;
    logic [31:0] sat_load_val, sat_cnt;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mdu_issue dut (
        .clk          (clk),
        .reset        (reset),
        .d_valid      (d_valid),
        .d_op         (d_op),
        .e_valid      (e_valid),
        .e_op         (e_op),
        .e_rs         (e_rs),
        .e_rt         (e_rt),
        .mdu_a        (mdu_a),
        .mdu_b        (mdu_b),
        .mdu_op       (mdu_op),
        .mdu_start    (mdu_start),
        .mdu_busy     (mdu_busy),
        .stall_md     (stall_md),
        .proto_err    (proto_err),
        .stall_cycles (stall_cycles)
    );

    mdu_issue_sat_counter #(.WIDTH(32)) u_sat (
        .clk        (clk),
        .reset      (sat_reset),
        .inc_i      (sat_inc),
        .load_i     (sat_load),
        .load_val_i (sat_load_val),
        .count_o    (sat_cnt)
    );

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_START: return {31'b0, mdu_start};
            S_STALL: return {31'b0, stall_md};
            S_ERR:   return {31'b0, proto_err};
            S_SCNT:  return stall_cycles;
            S_STATE: return {30'b0, dut.state_q};
            S_CNT:   return 32'(dut.cnt_q);
            S_OP:    return {28'b0, mdu_op};
            S_A:     return mdu_a;
            S_B:     return mdu_b;
            S_SAT:   return sat_cnt;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic exp_push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_run++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        d_valid  = 1'b0;
        d_op     = MDUOP_NONE;
        e_valid  = 1'b0;
        e_op     = MDUOP_NONE;
        e_rs     = 32'h0;
        e_rt     = 32'h0;
        mdu_busy = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset        = 1'b1;
        sat_reset    = 1'b1;
        sat_inc      = 1'b0;
        sat_load     = 1'b0;
        sat_load_val = 32'h0;
        tick();

        // reset state
        exp_push("rst_err", S_ERR, 32'd0);
        exp_push("rst_scnt", S_SCNT, 32'd0);
        exp_push("rst_state", S_STATE, 32'(ST_IDLE));
        exp_push("rst_cnt", S_CNT, 32'd0);
        exp_push("rst_op", S_OP, 32'(MDUOP_NONE));
        exp_push("rst_start", S_START, 32'd0);
        tick();
        reset = 1'b0;

        // mult with mflo waiting in D
        for (int c = 0; c < 8; c++) begin
            d_valid  = 1'b1;
            d_op     = MDUOP_MFLO;
            e_valid  = (c == 0);
            e_op     = (c == 0) ? MDUOP_MULT : MDUOP_NONE;
            e_rs     = 32'h1000_0000 + 32'(c);
            e_rt     = 32'hA5A5_0000 ^ 32'(c);
            mdu_busy = (c >= 1) && (c <= 6);
            exp_push($sformatf("mul_start_c%0d", c), S_START, 32'(c == 0));
            exp_push($sformatf("mul_stall_c%0d", c), S_STALL, 32'(c <= 6));
            exp_push($sformatf("mul_err_c%0d", c), S_ERR, 32'd0);
            exp_push($sformatf("mul_scnt_c%0d", c), S_SCNT, 32'(c));
            exp_push($sformatf("mul_state_c%0d", c), S_STATE,
                     32'(((c >= 1) && (c <= 6)) ? ST_MUL : ST_IDLE));
            exp_push($sformatf("mul_a_c%0d", c), S_A, 32'h1000_0000 + 32'(c));
            exp_push($sformatf("mul_b_c%0d", c), S_B, 32'hA5A5_0000 ^ 32'(c));
            if (c == 0) exp_push("mul_op_c0", S_OP, 32'(MDUOP_MULT));
            tick();
        end

        // div with mfhi waiting in D
        do_reset();
        for (int c = 0; c < 13; c++) begin
            d_valid  = 1'b1;
            d_op     = MDUOP_MFHI;
            e_valid  = (c == 0);
            e_op     = MDUOP_DIV;
            mdu_busy = (c >= 1) && (c <= 11);
            exp_push($sformatf("div_stall_c%0d", c), S_STALL, 32'(c <= 11));
            exp_push($sformatf("div_state_c%0d", c), S_STATE,
                     32'(((c >= 1) && (c <= 11)) ? ST_DIV : ST_IDLE));
            exp_push($sformatf("div_cnt_c%0d", c), S_CNT,
                     ((c >= 1) && (c <= 11)) ? 32'(12 - c) : 32'd0);
            exp_push($sformatf("div_err_c%0d", c), S_ERR, 32'd0);
            tick();
        end

        // MDU busy drops early: sticky protocol error
        do_reset();
        for (int c = 0; c < 21; c++) begin
            e_valid  = (c == 0);
            e_op     = MDUOP_MULTU;
            mdu_busy = (c >= 1) && (c <= 3);
            exp_push($sformatf("early_err_c%0d", c), S_ERR, 32'(c >= 5));
            if (c == 0) exp_push("early_start_nodv", S_START, 32'd1);
            if (c == 0) exp_push("early_stall_nodv", S_STALL, 32'd0);
            tick();
        end

        // reset mid-divu, then reset over a simultaneous start
        do_reset();
        d_valid = 1'b1;
        d_op    = MDUOP_MFHI;
        e_valid = 1'b1;
        e_op    = MDUOP_DIVU;
        exp_push("rmid_start", S_START, 32'd1);
        tick();
        e_valid  = 1'b0;
        mdu_busy = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        exp_push("rmid_scnt_pre", S_SCNT, 32'd4);
        exp_push("rmid_cnt_pre", S_CNT, 32'd8);
        exp_push("rmid_state_pre", S_STATE, 32'(ST_DIV));
        tick();
        reset    = 1'b0;
        mdu_busy = 1'b0;
        exp_push("rmid_cnt", S_CNT, 32'd0);
        exp_push("rmid_state", S_STATE, 32'(ST_IDLE));
        exp_push("rmid_scnt", S_SCNT, 32'd0);
        exp_push("rmid_stall", S_STALL, 32'd0);
        exp_push("rmid_err", S_ERR, 32'd0);
        tick();
        reset   = 1'b1;
        e_valid = 1'b1;
        e_op    = MDUOP_MULT;
        tick();
        reset   = 1'b0;
        e_valid = 1'b0;
        exp_push("rstart_cnt", S_CNT, 32'd0);
        exp_push("rstart_state", S_STATE, 32'(ST_IDLE));
        exp_push("rstart_err", S_ERR, 32'd0);
        tick();

        // stall qualifiers
        do_reset();
        d_valid  = 1'b1;
        d_op     = MDUOP_NONE;
        mdu_busy = 1'b1;
        exp_push("qual_opnone_stall", S_STALL, 32'd0);
        tick();
        d_valid = 1'b0;
        d_op    = MDUOP_MFLO;
        exp_push("qual_dinv_stall", S_STALL, 32'd0);
        exp_push("qual_idle_busy_err", S_ERR, 32'd1);
        tick();
        d_valid  = 1'b1;
        mdu_busy = 1'b0;
        exp_push("qual_quiet_stall", S_STALL, 32'd0);
        tick();
        mdu_busy = 1'b1;
        exp_push("qual_busy_stall", S_STALL, 32'd1);
        tick();

        // start while busy: new op wins
        do_reset();
        e_valid = 1'b1;
        e_op    = MDUOP_MULT;
        tick();
        e_valid  = 1'b0;
        mdu_busy = 1'b1;
        tick();
        e_valid  = 1'b1;
        e_op     = MDUOP_DIV;
        mdu_busy = 1'b0;
        exp_push("restart_start", S_START, 32'd1);
        exp_push("restart_cnt_pre", S_CNT, 32'd5);
        exp_push("restart_err_pre", S_ERR, 32'd0);
        tick();
        e_valid  = 1'b0;
        mdu_busy = 1'b1;
        exp_push("restart_err", S_ERR, 32'd1);
        exp_push("restart_state", S_STATE, 32'(ST_DIV));
        exp_push("restart_cnt", S_CNT, 32'd11);
        tick();

        // HI/LO move while busy, and e_valid gating of mdu_op
        do_reset();
        e_valid = 1'b1;
        e_op    = MDUOP_MULT;
        tick();
        mdu_busy = 1'b1;
        e_op     = MDUOP_MFHI;
        exp_push("move_op", S_OP, 32'(MDUOP_MFHI));
        exp_push("move_start", S_START, 32'd0);
        exp_push("move_err_pre", S_ERR, 32'd0);
        tick();
        e_valid = 1'b0;
        e_op    = MDUOP_MULT;
        exp_push("move_err", S_ERR, 32'd1);
        exp_push("gate_op", S_OP, 32'(MDUOP_NONE));
        exp_push("gate_start", S_START, 32'd0);
        tick();

        // saturating counter at the top of its range
        idle_inputs();
        sat_reset = 1'b1;
        tick();
        sat_reset    = 1'b0;
        sat_load     = 1'b1;
        sat_load_val = 32'hFFFF_FFFE;
        exp_push("sat_rst", S_SAT, 32'd0);
        tick();
        sat_load = 1'b0;
        sat_inc  = 1'b1;
        exp_push("sat_loaded", S_SAT, 32'hFFFF_FFFE);
        tick();
        exp_push("sat_inc1", S_SAT, 32'hFFFF_FFFF);
        tick();
        exp_push("sat_inc2", S_SAT, 32'hFFFF_FFFF);
        tick();
        sat_inc = 1'b0;
        exp_push("sat_inc3", S_SAT, 32'hFFFF_FFFF);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_issue.md
MDU_ISSUE -- requirements
Module: mdu_issue

Interface
REQ-001 SHALL use a single clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-002 SHALL have parameter MUL_BUSY, default 6: cycles mdu_busy stays high after a mult/multu Start cycle.
REQ-003 SHALL have parameter DIV_BUSY, default 11: cycles mdu_busy stays high after a div/divu Start cycle.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 d_valid  input  1  D-stage instruction is valid.
REQ-007 d_op  input  4  MDUOp code of the D-stage instruction.
REQ-008 e_valid  input  1  E-stage instruction is valid.
REQ-009 e_op  input  4  MDUOp code of the E-stage instruction.
REQ-010 e_rs, e_rt  input  32 each  forwarded E-stage operands.
REQ-011 mdu_a, mdu_b  output  32 each  operands to the MDU.
REQ-012 mdu_op  output  4  MDUOp to the MDU.
REQ-013 mdu_start  output  1  one-cycle issue strobe for mult/multu/div/divu.
REQ-014 mdu_busy  input  1  MDU Busy (MDU forces it low in the Start cycle).
REQ-015 stall_md  output  1  stalls the D stage.
REQ-016 proto_err  output  1  sticky protocol-violation flag.
REQ-017 stall_cycles  output  32  count of cycles with stall_md high.

Function
REQ-018 SHALL drive mdu_a=e_rs, mdu_b=e_rt combinationally, and mdu_op=e_op when e_valid else MDUOp_none.
REQ-019 SHALL assert mdu_start combinationally iff e_valid and e_op is mult, multu, div or divu.
REQ-020 SHALL keep a down-counter cnt plus FSM state IDLE/MUL/DIV, with own_busy = (cnt!=0).
REQ-021 On an edge with mdu_start: cnt<=MUL_BUSY and state<=MUL for mult/multu; cnt<=DIV_BUSY and state<=DIV for div/divu.
REQ-022 Otherwise, when cnt!=0: cnt<=cnt-1, and state<=IDLE when cnt==1.
REQ-023 SHALL assert stall_md = d_valid && d_op!=MDUOp_none && (mdu_start || own_busy || mdu_busy).
REQ-024 Start while own_busy: SHALL set proto_err and reload cnt/state per REQ-021 (new op wins).
REQ-025 e_valid with e_op mthi/mtlo/mfhi/mflo while own_busy: SHALL set proto_err; mdu_op is still passed through.
REQ-026 In every non-reset cycle with mdu_start=0 and mdu_busy!=own_busy: SHALL set proto_err at the next edge.
REQ-027 proto_err SHALL stay set until reset.
REQ-028 stall_cycles SHALL increment on every edge where stall_md=1, and saturate at 32'hFFFF_FFFF.

Reset
REQ-029 reset SHALL force cnt=0, state=IDLE, proto_err=0 and stall_cycles=0 at the edge, overriding a simultaneous mdu_start.
REQ-030 Reset mid-operation SHALL abandon the tracked op; the combinational outputs follow their inputs and need no reset value.

Structure
REQ-031 MDUOp codes (none=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8) and the MUL_BUSY/DIV_BUSY defaults SHALL live in the shared constants header.
REQ-032 SHALL be flat; the stall_cycles saturating counter MAY be a sub-module sat_counter.

Verification
REQ-033 mult in E at cycle 0, mflo in D cycles 0-7, mdu_busy high cycles 1-6 -> mdu_start high only in cycle 0; stall_md high cycles 0-6, low cycle 7; proto_err=0; stall_cycles=7.
REQ-034 div at cycle 0 with mdu_busy high cycles 1-11 and mfhi in D -> stall_md high cycles 0-11; state DIV in cycles 1-11, IDLE in cycle 12.
REQ-035 mult at cycle 0, mdu_busy dropping after cycle 3 -> proto_err=1 from cycle 5 and stays set through cycle 20.
REQ-036 divu at cycle 0, reset in cycle 4 -> cnt=0, state IDLE and stall_cycles=0 in cycle 5; with mdu_busy low, stall_md=0.
REQ-037 stall_cycles preloaded to 32'hFFFF_FFFE, then 3 stall cycles -> value stays at 32'hFFFF_FFFF.
REQ-038 d_op=MDUOp_none with mdu_busy=1 -> stall_md=0; with d_valid=0 -> stall_md=0.
